// File: rtl/toggle_req_sender_pkg.sv
// Shared definitions for both ends of the two-phase toggle request/acknowledge link.
package toggle_req_sender_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_SETUP = SETUP,
        ST_WAIT  = WAIT
    } state_e;

endpackage

// File: rtl/toggle_sync2.sv
// Two-flop synchroniser for a toggle/level signal crossing into the clk domain.
module toggle_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/toggle_req_sender.sv
// Sender side of the toggle req/ack crossing: buffers words in a FIFO and hands
// them across one at a time, waiting for each returned ack toggle.
module toggle_req_sender
    import toggle_req_sender_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned PTRW  = 2
) (
    input  logic             clk,
    input  logic             re,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic [WIDTH-1:0] Da,
    output logic             ReqA,
    input  logic             AckA,
    output logic             busy,
    output logic             done,
    output logic [7:0]       tx_count
);

    logic [PTRW:0]      wr_ptr_q;
    logic [PTRW:0]      rd_ptr_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               overflow_q;
    state_e             state_q;
    logic               req_q;
    logic [WIDTH-1:0]   da_q;
    logic               done_q;
    logic [7:0]         tx_count_q;
    logic               ack_s2;
    logic               push;
    logic               pop;

    toggle_sync2 u_ack_sync (
        .clk_i (clk),
        .rst_i (re),
        .d_i   (AckA),
        .q_o   (ack_s2)
    );

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full  = (wr_ptr_q[PTRW] != rd_ptr_q[PTRW]) &&
                   (wr_ptr_q[PTRW-1:0] == rd_ptr_q[PTRW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = wr_en && !full;
    assign pop   = (state_q == ST_IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTRW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge re) begin
        if (re) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (PTRW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (PTRW+1)'(1);
            end
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Da is loaded one cycle ahead of the req toggle and held until the ack returns.
    always_ff @(posedge clk or posedge re) begin
        if (re) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            da_q       <= '0;
            done_q     <= 1'b0;
            tx_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        da_q    <= mem_q[rd_ptr_q[PTRW-1:0]];
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    req_q   <= ~req_q;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ack_s2 == req_q) begin
                        done_q     <= 1'b1;
                        tx_count_q <= tx_count_q + 8'd1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign overflow = overflow_q;
    assign Da       = da_q;
    assign ReqA     = req_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign tx_count = tx_count_q;

endmodule

// File: tb/tb_toggle_req_sender.sv
// Randomised bench for toggle_req_sender against a transaction-level link model.
module tb_toggle_req_sender;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         re;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         full;
    logic         empty;
    logic         overflow;
    logic [W-1:0] Da;
    logic         ReqA;
    logic         AckA;
    logic         busy;
    logic         done;
    logic [7:0]   tx_count;

    toggle_req_sender #(.WIDTH(W), .DEPTH(D), .PTRW(2)) dut (
        .clk      (clk),
        .re       (re),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .Da       (Da),
        .ReqA     (ReqA),
        .AckA     (AckA),
        .busy     (busy),
        .done     (done),
        .tx_count (tx_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: buffered words, age of in-flight word (-1 none, 0 just loaded, 1 waiting)
    logic [W-1:0] m_q[$];
    int           m_age;
    logic         m_req;
    logic         m_done;
    logic         m_ovf;
    logic [W-1:0] m_da;
    logic [7:0]   m_cnt;
    logic [1:0]   m_ack_hist;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_age      = -1;
        m_req      = 1'b0;
        m_done     = 1'b0;
        m_ovf      = 1'b0;
        m_da       = '0;
        m_cnt      = '0;
        m_ack_hist = 2'b00;
    endtask

    // One rising edge of the link, using the inputs held across that edge.
    task automatic model_edge();
        bit         was_full;
        logic       ack_seen;
        was_full = (m_q.size() == D);
        ack_seen = m_ack_hist[1];
        m_done   = 1'b0;
        if (m_age < 0) begin
            if (m_q.size() > 0) begin
                m_da  = m_q.pop_front();
                m_age = 0;
            end
        end else if (m_age == 0) begin
            m_req = ~m_req;
            m_age = 1;
        end else if (ack_seen == m_req) begin
            m_done = 1'b1;
            m_cnt  = m_cnt + 8'd1;
            m_age  = -1;
        end
        if (wr_en) begin
            if (was_full) m_ovf = 1'b1;
            else          m_q.push_back(wr_data);
        end
        m_ack_hist = {m_ack_hist[0], AckA};
    endtask

    task automatic check_all();
        check("ReqA",     32'(ReqA),     32'(m_req));
        check("Da",       32'(Da),       32'(m_da));
        check("done",     32'(done),     32'(m_done));
        check("busy",     32'(busy),     32'(m_age >= 0));
        check("full",     32'(full),     32'(m_q.size() == D));
        check("empty",    32'(empty),    32'(m_q.size() == 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("tx_count", 32'(tx_count), 32'(m_cnt));
    endtask

    // Check outputs, drive inputs at the falling edge, then advance the model at the rising edge.
    task automatic step(input bit we, input logic [W-1:0] wd, input bit ack_en, input int ack_pct);
        @(negedge clk);
        check_all();
        wr_en   = we;
        wr_data = wd;
        if (ack_en && (AckA != ReqA) && ($urandom_range(99) < 32'(ack_pct))) AckA = ReqA;
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        logic [W-1:0] seq [4];
        int           guard;
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

        re      = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        AckA    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        re = 1'b0;

        repeat (20) step(1'b0, '0, 1'b1, 100);

        step(1'b1, 8'hA5, 1'b1, 35);
        repeat (25) step(1'b0, '0, 1'b1, 35);

        for (int i = 0; i < 4; i++) step(1'b1, seq[i], 1'b1, 100);
        repeat (40) step(1'b0, '0, 1'b1, 100);

        for (int i = 0; i < 6; i++) step(1'b1, W'($urandom), 1'b0, 0);
        repeat (10) step(1'b0, '0, 1'b0, 0);
        repeat (50) step(1'b0, '0, 1'b1, 100);

        step(1'b1, 8'h5A, 1'b0, 0);
        repeat (50) step(1'b0, '0, 1'b0, 0);
        repeat (10) step(1'b0, '0, 1'b1, 100);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 30, W'($urandom), 1'b1, 50);
        end

        step(1'b1, 8'hC3, 1'b0, 0);
        guard = 0;
        while (!(m_age >= 1 && m_req) && guard < 20) begin
            step(1'b0, '0, 1'b0, 0);
            guard++;
        end
        check("reach_wait_req1", 32'(m_age >= 1 && m_req), 32'(1));

        #2;
        re = 1'b1;
        #1;
        check("async_rst_ReqA",  32'(ReqA),     32'(0));
        check("async_rst_Da",    32'(Da),       32'(0));
        check("async_rst_count", 32'(tx_count), 32'(0));
        check("async_rst_empty", 32'(empty),    32'(1));
        check("async_rst_busy",  32'(busy),     32'(0));
        AckA  = 1'b0;
        wr_en = 1'b0;
        model_reset();
        @(negedge clk);
        re = 1'b0;
        repeat (20) step(1'b0, '0, 1'b1, 100);
        step(1'b1, 8'h3C, 1'b1, 100);
        repeat (15) step(1'b0, '0, 1'b1, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
